lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store unit that initiates accesses to the word-addressed data memory on behalf of the core. Accepts byte/halfword/word load and store requests over a valid/ready handshake, converts byte addresses to word indices, performs read-modify-write for sub-word stores, and sign- or zero-extends load data. Sits between the core's execute stage and the data memory, driving its `addr`/`wd`/`we` inputs and consuming `rd`.

## Interface
- `DEPTH`, 64: memory depth in 32-bit words; must be a power of two.
- `AW`, 32: core byte-address width.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: core request present.
- `req_ready` out 1: unit can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in AW: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` out 1: response available.
- `resp_ready` in 1: core accepts response.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned, illegal size, or out-of-range address.
- `mem_addr` out 32: word index to memory `addr`.
- `mem_wd` out 32: write data to memory `wd`.
- `mem_we` out 1: write enable to memory `we`.
- `mem_rd` in 32: memory read data; combinational from `mem_addr`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch all request fields. Legal request goes to ACCESS; error request goes to RESP with `resp_err`=1 and no memory access.
- Error conditions: `req_size`=11; half with `addr[0]`=1; word with `addr[1:0]`≠0; word index `addr[AW-1:2]` ≥ DEPTH.
- ACCESS, one cycle: `mem_addr` = latched `addr[AW-1:2]`, zero-extended to 32 bits.
  - Load: extract the byte/half selected by `addr[1:0]` from `mem_rd` (little-endian: byte 0 = [7:0]), extend per `req_unsigned`, register into `resp_rdata`.
  - Word store: `mem_wd` = wdata, `mem_we`=1.
  - Sub-word store: `mem_wd` = `mem_rd` with the selected lane(s) replaced by wdata[7:0] or wdata[15:0], `mem_we`=1 (same-cycle RMW, legal because read is combinational).
  - Then go to RESP.
- RESP: `resp_valid`=1, outputs held stable until `resp_ready`. On `resp_valid && resp_ready`, go to IDLE. No new request accepted in RESP (`req_ready`=0).
- `mem_we` is 1 only in ACCESS for stores, and is gated by `!rst`. A reset asserted during ACCESS must not write memory.
- Outside ACCESS: `mem_we`=0, `mem_addr`=0, `mem_wd`=0.

## Timing
- Reset values: state IDLE, `req_ready`=1 (the cycle after reset), `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_we`=0, `mem_addr`=0, `mem_wd`=0.
- Handshake at edge N: ACCESS in cycle N+1, memory write at edge N+2, `resp_valid` from cycle N+2.
- Minimum throughput: one request per 3 cycles with `resp_ready` tied high.
- Error request accepted at edge N: `resp_valid`/`resp_err` in cycle N+1.
- A `req_valid` presented while `req_ready`=0 is ignored; the core holds it.
- `resp_ready` high before `resp_valid` is ignored.
- Reset in any state returns to IDLE at that edge and discards the pending response.

## Structure
- `lsu_pkg`: size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`), FSM state enum, and the misalignment check function.
- Sub-module `lsu_align`: purely combinational lane extract/extend for loads and lane merge for stores, driven by `addr[1:0]`, size, and unsigned flag. The FSM stays in `lsu_ctrl`.

## Test plan
- Word store 0xDEADBEEF to addr 0x10, then word load from 0x10:
  - `mem_addr`=4 with `mem_we`=1 for exactly one cycle.
  - Load returns 0xDEADBEEF with `resp_err`=0, and `resp_valid` 2 cycles after the handshake.
- Word 0x11223344 at addr 0x20:
  - Byte store 0xAA to 0x22 makes the word 0x11AA3344.
  - Signed byte load from 0x22 returns 0xFFFFFFAA; unsigned byte load returns 0x000000AA.
- Signed half load from 0x22 after the previous test returns 0x000011AA. Half store 0x8001 to 0x20 then signed half load returns 0xFFFF8001.
- Error cases each respond with `resp_err`=1, `resp_rdata`=0, `mem_we` never asserted, and response in cycle N+1:
  - Half load from 0x03.
  - Word store to 0x06.
  - `req_size`=11.
  - Word load from 0x100 (index 64 ≥ DEPTH).
- Hold `resp_ready`=0 for 5 cycles in RESP: `resp_valid` and `resp_rdata` stay stable, `req_ready`=0, and a concurrent `req_valid` is not accepted.
- Assert `rst` during ACCESS of a store of 0x55 to 0x08: memory word 2 is unchanged, the next cycle is IDLE, and `resp_valid`=0.

Source files
------------

// File: rtl/lsu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the load/store unit.
//               - Access-size encodings.
//               - FSM state encodings.
//               - Alignment check helper.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Access-size encodings carried on req_size.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // FSM state encodings.
    localparam int c_STATE_W = 2;
    typedef logic [c_STATE_W-1:0] lsu_state_t;
    localparam lsu_state_t c_ST_IDLE   = 2'd0;
    localparam lsu_state_t c_ST_ACCESS = 2'd1;
    localparam lsu_state_t c_ST_RESP   = 2'd2;

    // Returns 1 when the byte offset is not naturally aligned for the size.
    // Bytes are always aligned; the illegal size is flagged separately.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
        logic r;
        r = 1'b0;
        case (size)
            SZ_HALF: r = off[0];
            SZ_WORD: r = (off != 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane handling for the load/store unit.
//               Loads : extract the byte/half at i_byte_off from i_mem_rd and
//                       sign- or zero-extend it.
//               Stores: merge the low byte/half of i_wdata into i_mem_rd at
//                       i_byte_off (word stores pass i_wdata through).
// Ports       : i_byte_off   - address bits [1:0]
//               i_size       - access size (SZ_*)
//               i_unsigned   - 1 = zero-extend loads
//               i_mem_rd     - current memory word
//               i_wdata      - right-aligned store data
//               o_load_data  - extended load result
//               o_store_data - merged word to write back
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_byte_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_mem_rd,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Little-endian lane select: byte 0 lives in [7:0].
    assign w_byte = i_mem_rd[{i_byte_off, 3'b000} +: 8];
    assign w_half = i_byte_off[1] ? i_mem_rd[31:16] : i_mem_rd[15:0];

    always_comb begin
        o_load_data  = i_mem_rd;
        o_store_data = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_load_data  = {{24{~i_unsigned & w_byte[7]}}, w_byte};
                o_store_data = i_mem_rd;
                o_store_data[{i_byte_off, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_load_data  = {{16{~i_unsigned & w_half[15]}}, w_half};
                o_store_data = i_mem_rd;
                if (i_byte_off[1]) begin
                    o_store_data[31:16] = i_wdata[15:0];
                end else begin
                    o_store_data[15:0]  = i_wdata[15:0];
                end
            end
            default: begin
                o_load_data  = i_mem_rd;
                o_store_data = i_wdata;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Load/store unit. Accepts byte/half/word requests over a
//               valid/ready handshake, drives a word-addressed memory with a
//               combinational read port, performs same-cycle read-modify-
//               write for sub-word stores and returns extended load data.
// Ports       : clk, rst                       - clock, sync active-high reset
//               req_valid/req_ready            - request handshake
//               req_we/req_size/req_unsigned   - access type
//               req_addr/req_wdata             - byte address, store data
//               resp_valid/resp_ready          - response handshake
//               resp_rdata/resp_err            - load data, error flag
//               mem_addr/mem_wd/mem_we/mem_rd  - data memory port
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wd,
    output logic          mem_we,
    input  logic [31:0]   mem_rd
);

    localparam logic [AW-1:0] c_DEPTH = AW'(DEPTH);

    lsu_state_t     r_state;
    logic           r_we;
    logic [1:0]     r_size;
    logic           r_unsigned;
    logic [AW-1:0]  r_addr;
    logic [31:0]    r_wdata;
    logic [31:0]    r_rdata;
    logic           r_err;

    logic           w_accept;
    logic           w_req_err;
    logic           w_in_access;
    logic [31:0]    w_load_data;
    logic [31:0]    w_store_data;

    assign w_accept    = req_valid && req_ready;
    assign w_in_access = (r_state == c_ST_ACCESS);

    // Request is rejected up front so an errored access never reaches memory.
    assign w_req_err = (req_size == SZ_ILL)
                     || is_misaligned(req_size, req_addr[1:0])
                     || ({2'b00, req_addr[AW-1:2]} >= c_DEPTH);

    lsu_align u_align (
        .i_byte_off   (r_addr[1:0]),
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .i_mem_rd     (mem_rd),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_data (w_store_data)
    );

    assign req_ready  = (r_state == c_ST_IDLE);
    assign resp_valid = (r_state == c_ST_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    // Memory port is quiet outside ACCESS. The write enable is also gated by
    // rst so a reset landing on the ACCESS cycle cannot corrupt memory.
    assign mem_addr = w_in_access ? 32'(r_addr[AW-1:2]) : 32'd0;
    assign mem_we   = w_in_access && r_we && !rst;
    assign mem_wd   = (w_in_access && r_we) ? w_store_data : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_we       <= 1'b0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_rdata    <= 32'd0;
                        if (w_req_err) begin
                            r_err   <= 1'b1;
                            r_state <= c_ST_RESP;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= c_ST_ACCESS;
                        end
                    end
                end
                c_ST_ACCESS: begin
                    r_rdata <= r_we ? 32'd0 : w_load_data;
                    r_state <= c_ST_RESP;
                end
                c_ST_RESP: begin
                    if (resp_ready) begin
                        r_rdata <= 32'd0;
                        r_err   <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ctrl
// Description : Directed self-checking bench for lsu_ctrl with a 64-word
//               behavioural memory (combinational read, clocked write).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    lsu_ctrl #(.DEPTH(64), .AW(32)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_we       (mem_we),
        .mem_rd       (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory.
    logic [31:0] mem [0:63];
    assign mem_rd = mem[mem_addr[5:0]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[5:0]] <= mem_wd;
    end

    // Write-enable monitor, sampled mid-cycle.
    int          we_total = 0;
    logic [31:0] last_we_addr = 32'd0;
    always @(negedge clk) begin
        if (mem_we) begin
            we_total     = we_total + 1;
            last_we_addr = mem_addr;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete transaction with resp_ready high. lat counts cycles from
    // the handshake edge until resp_valid is seen (0 if the bound expired).
    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int wes);
        int we0;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        resp_ready   = 1'b1;
        we0          = we_total;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = i;
                break;
            end
        end
        rd  = resp_rdata;
        er  = resp_err;
        wes = we_total - we0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wes;
    int          we_snap;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[8] = 32'h11223344;
        mem[2] = 32'hCAFEF00D;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = SZ_WORD;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        resp_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Reset state.
        check("rst req_ready",  32'(req_ready),  32'd1);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst resp_rdata", resp_rdata,      32'd0);
        check("rst resp_err",   32'(resp_err),   32'd0);
        check("rst mem_we",     32'(mem_we),     32'd0);
        check("rst mem_addr",   mem_addr,        32'd0);
        check("rst mem_wd",     mem_wd,          32'd0);

        // Word store then word load.
        xact(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, wes);
        check("sw err",     32'(er),  32'd0);
        check("sw rdata",   rd,       32'd0);
        check("sw lat",     32'(lat), 32'd2);
        check("sw we cnt",  32'(wes), 32'd1);
        check("sw we addr", last_we_addr, 32'd4);
        check("sw mem4",    mem[4],   32'hDEADBEEF);
        xact(1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, rd, er, lat, wes);
        check("lw data",   rd,       32'hDEADBEEF);
        check("lw err",    32'(er),  32'd0);
        check("lw lat",    32'(lat), 32'd2);
        check("lw no we",  32'(wes), 32'd0);

        // Sub-word stores and extending loads on word 8 (0x11223344).
        xact(1'b1, SZ_BYTE, 1'b0, 32'h22, 32'hFFFFFFAA, rd, er, lat, wes);
        check("sb mem8",   mem[8],   32'h11AA3344);
        check("sb we cnt", 32'(wes), 32'd1);
        xact(1'b0, SZ_BYTE, 1'b0, 32'h22, 32'd0, rd, er, lat, wes);
        check("lb signed", rd, 32'hFFFFFFAA);
        xact(1'b0, SZ_BYTE, 1'b1, 32'h22, 32'd0, rd, er, lat, wes);
        check("lbu",       rd, 32'h000000AA);
        xact(1'b0, SZ_HALF, 1'b0, 32'h22, 32'd0, rd, er, lat, wes);
        check("lh hi",     rd, 32'h000011AA);
        xact(1'b1, SZ_HALF, 1'b0, 32'h20, 32'h00008001, rd, er, lat, wes);
        check("sh mem8",   mem[8], 32'h11AA8001);
        xact(1'b0, SZ_HALF, 1'b0, 32'h20, 32'd0, rd, er, lat, wes);
        check("lh lo",     rd, 32'hFFFF8001);
        xact(1'b0, SZ_HALF, 1'b1, 32'h20, 32'd0, rd, er, lat, wes);
        check("lhu lo",    rd, 32'h00008001);

        // Error requests: one-cycle response, no memory write.
        xact(1'b0, SZ_HALF, 1'b0, 32'h03, 32'd0, rd, er, lat, wes);
        check("e_half err",   32'(er),  32'd1);
        check("e_half rdata", rd,       32'd0);
        check("e_half lat",   32'(lat), 32'd1);
        xact(1'b1, SZ_WORD, 1'b0, 32'h06, 32'h12345678, rd, er, lat, wes);
        check("e_word err",   32'(er),  32'd1);
        check("e_word lat",   32'(lat), 32'd1);
        check("e_word no we", 32'(wes), 32'd0);
        xact(1'b1, SZ_ILL, 1'b0, 32'h00, 32'h12345678, rd, er, lat, wes);
        check("e_size err",   32'(er),  32'd1);
        check("e_size lat",   32'(lat), 32'd1);
        check("e_size no we", 32'(wes), 32'd0);
        check("e_size mem0",  mem[0],   32'd0);
        xact(1'b0, SZ_WORD, 1'b0, 32'h100, 32'd0, rd, er, lat, wes);
        check("e_range err",   32'(er),  32'd1);
        check("e_range rdata", rd,       32'd0);
        check("e_range lat",   32'(lat), 32'd1);

        // Back-pressure: hold resp_ready low for five cycles in RESP.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = SZ_WORD;
        req_addr   = 32'h10;
        resp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("hold valid0", 32'(resp_valid), 32'd1);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'h12345678;
        we_snap   = we_total;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold valid", 32'(resp_valid), 32'd1);
            check("hold rdata", resp_rdata,      32'hDEADBEEF);
            check("hold ready", 32'(req_ready),  32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        check("hold release valid", 32'(resp_valid), 32'd0);
        check("hold release ready", 32'(req_ready),  32'd1);
        repeat (2) @(negedge clk);
        check("hold no we",  32'(we_total - we_snap), 32'd0);
        check("hold mem12",  mem[12], 32'd0);

        // Reset during the ACCESS cycle of a byte store to word 2.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = SZ_BYTE;
        req_addr   = 32'h08;
        req_wdata  = 32'h55;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        we_snap   = we_total;
        @(negedge clk);
        check("rstacc mem_we", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstacc ready", 32'(req_ready),  32'd1);
        check("rstacc valid", 32'(resp_valid), 32'd0);
        check("rstacc mem2",  mem[2],          32'hCAFEF00D);
        check("rstacc no we", 32'(we_total - we_snap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
